bg_mem_writer: RTL and testbench
================================

# bg_mem_writer

Writes a raster-ordered pixel stream into the background image memory at a caller-chosen start address, so that the background display path can later tile it across the screen. Accepts 12-bit RGB pixels over a valid/ready handshake, generates linear addresses incrementally (start + row*width + col, with no multiplier), and drives a single-port write interface. Used at boot and whenever a new background image is loaded.

## Interface
- `memory_depth_base`, default 19: address width of the image memory.
- `pixel_width`, default 12: RGB444 pixel width.
- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a transfer; sampled only in IDLE.
- `memory_start_addr` in `memory_depth_base`: base address of the image, latched on start.
- `width` in 10: image width in pixels, latched on start.
- `height` in 10: image height in pixels, latched on start.
- `pix_data` in `pixel_width`: incoming pixel.
- `pix_valid` in 1: `pix_data` is valid.
- `pix_ready` out 1: block accepts a pixel this cycle.
- `mem_addr` out `memory_depth_base`: write address.
- `mem_data` out `pixel_width`: write data.
- `mem_we` out 1: write strobe, one cycle per pixel.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at transfer completion.

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: on `start`, latch base/width/height and clear x, y, and offset.
  - If width==0 or height==0, go to DONE with no writes.
  - Otherwise go to WRITE.
- WRITE: `pix_ready`=1 (decoded from state). Each accept (`pix_valid & pix_ready`) does the following:
  - Registers `mem_addr`=base+offset (modulo 2^`memory_depth_base`), `mem_data`=`pix_data`, and `mem_we`=1.
  - Increments offset by 1.
  - Steps x. When x==width-1, sets x=0 and y=y+1.
  - On the accept where x==width-1 and y==height-1, goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in WRITE and DONE.
- `start` outside IDLE is ignored. Changes to `width`/`height`/`memory_start_addr` after start have no effect.
- Offset register is `memory_depth_base` bits wide. Address wraps silently past the top of memory; no error flag.
- Gaps in `pix_valid` stall the transfer indefinitely with state held. `mem_we`=0 on stall cycles.
- `rst` at any time aborts the transfer immediately. Pixels already written stay written.

## Timing
- Reset values: `pix_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0. State IDLE, x=y=offset=0.
- `start` high at cycle t in IDLE: state WRITE, `busy`=1 and `pix_ready`=1 at t+1.
- Accept at cycle k: `mem_we`/`mem_addr`/`mem_data` valid at k+1 for one cycle. Write latency is one cycle.
- Last accept at cycle k:
  - At k+1: state DONE, `done`=1, `pix_ready`=0, and the final `mem_we`=1 in the same cycle.
  - At k+2: IDLE. A new `start` is accepted at k+2.
- Zero-size start at t: `done`=1 at t+1, IDLE at t+2, `mem_we` never asserted.
- Throughput: one pixel per cycle sustained.
- `mem_we` is deasserted the cycle after any non-accept cycle.

## Structure
- Shared package holds:
  - The state enum (IDLE/WRITE/DONE).
  - `memory_depth_base`=19 and pixel width 12 as constants, shared with the display-side readers.
- One sub-module, `raster_counter`: x/y counters with width/height compare, `step` input, and a `last` output.
- The FSM, offset adder and output registers stay in `bg_mem_writer`.

## Test plan
- Basic 4×2 image, base 0x100, `pix_valid` held high, pixels 0x001..0x008:
  - Writes 0x100..0x107 with matching data on consecutive cycles.
  - `done` is high in the cycle of the last write.
- Same transfer with `pix_valid` toggling every other cycle:
  - Identical address/data sequence.
  - `mem_we` only on cycles following accepts.
  - `done` is a single pulse.
- width=0, height=5, `start`:
  - `done` pulses at t+1.
  - No `mem_we`.
  - `pix_ready` never high.
- Base 0x7FFFE, 2×2 image: addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- `start` re-asserted mid-transfer and `width` changed mid-transfer: both ignored, and the transfer completes with the original geometry.
- `rst` asserted after 3 of 8 pixels:
  - Next cycle all outputs are at reset values.
  - A fresh `start` restarts at the base address.

Source files
------------

// File: rtl/bg_mem_writer_pkg.sv
// Shared constants and FSM state type for the background image memory writer
// and the display-side readers of the same memory.
package bg_mem_writer_pkg;

  localparam int mem_depth_bits = 19;
  localparam int pix_bits       = 12;
  localparam int dim_bits       = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } writer_state_e;

endpackage

// File: rtl/bg_mem_writer_raster_counter.sv
// Raster x/y position tracker: advances one pixel per step and flags the
// final pixel of the image.
module raster_counter
  import bg_mem_writer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                step,
  input  logic [dim_bits-1:0] width,
  input  logic [dim_bits-1:0] height,
  output logic                last
);

  logic [dim_bits-1:0] x;
  logic [dim_bits-1:0] y;
  logic                x_end;

  assign x_end = (x == (width - 10'd1));
  assign last  = x_end && (y == (height - 10'd1));

  // x/y position, wrapping x into the next row at the end of each line
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= 10'd0;
      y <= 10'd0;
    end else if (clear) begin
      x <= 10'd0;
      y <= 10'd0;
    end else if (step) begin
      if (x_end) begin
        x <= 10'd0;
        y <= y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

endmodule

// File: rtl/bg_mem_writer.sv
// Streams raster-ordered pixels into the background image memory starting at
// a latched base address; addresses come from a running offset, not a multiply.
module bg_mem_writer
  import bg_mem_writer_pkg::*;
#(
  parameter int memory_depth_base = mem_depth_bits,
  parameter int pixel_width       = pix_bits
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [memory_depth_base-1:0] memory_start_addr,
  input  logic [dim_bits-1:0]          width,
  input  logic [dim_bits-1:0]          height,
  input  logic [pixel_width-1:0]       pix_data,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  output logic [memory_depth_base-1:0] mem_addr,
  output logic [pixel_width-1:0]       mem_data,
  output logic                         mem_we,
  output logic                         busy,
  output logic                         done
);

  localparam logic [memory_depth_base-1:0] addr_one = {{(memory_depth_base-1){1'b0}}, 1'b1};

  writer_state_e                state;
  writer_state_e                next_state;
  logic [memory_depth_base-1:0] base_addr;
  logic [memory_depth_base-1:0] offset;
  logic [dim_bits-1:0]          img_width;
  logic [dim_bits-1:0]          img_height;
  logic                         start_go;
  logic                         accept;
  logic                         last;

  assign start_go = (state == IDLE) && start;
  assign accept   = pix_valid && pix_ready;

  raster_counter u_raster (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_go),
    .step   (accept),
    .width  (img_width),
    .height (img_height),
    .last   (last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next-state logic; a zero-sized image skips straight to DONE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if ((width == 10'd0) || (height == 10'd0)) begin
            next_state = DONE;
          end else begin
            next_state = WRITE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WRITE: begin
        if (accept && last) begin
          next_state = DONE;
        end else begin
          next_state = WRITE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // handshake and status outputs decoded from state
  always_comb begin
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
      end
      WRITE: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        pix_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
      end
    endcase
  end

  // geometry latch, offset accumulator and registered memory write port
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr  <= '0;
      offset     <= '0;
      img_width  <= 10'd0;
      img_height <= 10'd0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_we     <= 1'b0;
    end else begin
      mem_we <= accept;
      if (start_go) begin
        base_addr  <= memory_start_addr;
        img_width  <= width;
        img_height <= height;
        offset     <= '0;
      end else if (accept) begin
        mem_addr <= base_addr + offset;
        mem_data <= pix_data;
        offset   <= offset + addr_one;
      end
    end
  end

endmodule

// File: tb/tb_bg_mem_writer.sv
// Directed bench for bg_mem_writer: table of transfers checked against
// hand-computed write sequences, plus a mid-transfer reset sequence.
module tb_bg_mem_writer;
  import bg_mem_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [18:0] memory_start_addr;
  logic [9:0]  width;
  logic [9:0]  height;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [18:0] mem_addr;
  logic [11:0] mem_data;
  logic        mem_we;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  bg_mem_writer #(.memory_depth_base(19), .pixel_width(12)) dut (
    .clk(clk), .rst(rst), .start(start), .memory_start_addr(memory_start_addr),
    .width(width), .height(height), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [18:0] base;
    logic [9:0]  w;
    logic [9:0]  h;
    bit          toggle;
    bit          disturb;
    int          n;
    logic [18:0] first;
  } vec_t;

  vec_t vecs[7];
  int total = 0;
  int bad = 0;

  // monitor state
  int          cyc = 0;
  logic [18:0] wa_q[$];
  logic [11:0] wd_q[$];
  int          done_cnt, done_cyc, last_we_cyc, we_err, rdy_cnt;
  logic        acc_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we !== acc_prev) we_err++;
      if (mem_we) begin
        wa_q.push_back(mem_addr);
        wd_q.push_back(mem_data);
        last_we_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pix_ready) rdy_cnt++;
    end
    acc_prev = pix_valid & pix_ready & !rst;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_we_cyc = -2;
    we_err = 0;
    rdy_cnt = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int idx;
    int k;
    int s_cyc;
    logic [18:0] ea;
    clear_mon();
    @(posedge clk); #1;
    memory_start_addr = v.base;
    width = v.w;
    height = v.h;
    start = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(pix_ready), (v.n > 0) ? 32'd1 : 32'd0);
    idx = 0;
    k = 0;
    while (idx < v.n && k < 200) begin
      if (v.disturb && idx == 2) begin
        start = 1'b1;
        width = 10'd7;
        height = 10'd9;
        memory_start_addr = 19'h00000;
      end else begin
        start = 1'b0;
      end
      pix_valid = !(v.toggle && k[0]);
      pix_data = 12'(idx + 1);
      if (pix_valid && pix_ready) idx++;
      k++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    pix_valid = 1'b0;
    check("accepted", 32'(idx), 32'(v.n));
    repeat (3) @(posedge clk);
    #1;
    check("nwrites", 32'(wa_q.size()), 32'(v.n));
    for (int i = 0; i < wa_q.size() && i < v.n; i++) begin
      ea = v.first + 19'(i);
      check("waddr", 32'(wa_q[i]), 32'(ea));
      check("wdata", 32'(wd_q[i]), 32'(i + 1));
    end
    check("done_pulses", 32'(done_cnt), 32'd1);
    if (v.n > 0) begin
      check("done_with_last_we", 32'(done_cyc), 32'(last_we_cyc));
    end else begin
      check("done_latency", 32'(done_cyc), 32'(s_cyc));
      check("ready_never", 32'(rdy_cnt), 32'd0);
    end
    check("we_follows_accept", 32'(we_err), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{base:19'h00100, w:10'd4, h:10'd2, toggle:1'b0, disturb:1'b0, n:8, first:19'h00100};
    vecs[1] = '{base:19'h00100, w:10'd4, h:10'd2, toggle:1'b1, disturb:1'b0, n:8, first:19'h00100};
    vecs[2] = '{base:19'h7FFFE, w:10'd2, h:10'd2, toggle:1'b0, disturb:1'b0, n:4, first:19'h7FFFE};
    vecs[3] = '{base:19'h00005, w:10'd1, h:10'd3, toggle:1'b1, disturb:1'b0, n:3, first:19'h00005};
    vecs[4] = '{base:19'h00200, w:10'd0, h:10'd5, toggle:1'b0, disturb:1'b0, n:0, first:19'h00200};
    vecs[5] = '{base:19'h00300, w:10'd3, h:10'd0, toggle:1'b0, disturb:1'b0, n:0, first:19'h00300};
    vecs[6] = '{base:19'h00040, w:10'd3, h:10'd2, toggle:1'b0, disturb:1'b1, n:6, first:19'h00040};

    rst = 1'b1;
    start = 1'b0;
    memory_start_addr = 19'h0;
    width = 10'd0;
    height = 10'd0;
    pix_data = 12'h0;
    pix_valid = 1'b0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(pix_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // reset after 3 of 8 pixels, then a fresh transfer from the same base
    clear_mon();
    @(posedge clk); #1;
    memory_start_addr = 19'h00100;
    width = 10'd4;
    height = 10'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pix_valid = 1'b1;
      pix_data = 12'(i + 1);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ready", 32'(pix_ready), 32'd0);
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_addr", 32'(mem_addr), 32'd0);
    check("abort_data", 32'(mem_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_nwrites", 32'(wa_q.size()), 32'd3);
    if (wa_q.size() >= 3) check("abort_last_addr", 32'(wa_q[2]), 32'h102);
    rst = 1'b0;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
